// File: rtl/icb_ra_pkg.sv
// rtl/icb_ra_pkg.sv - shared types and constants for the ICB register-access initiator
package icb_ra_pkg;

    // Word buffer geometry
    localparam int BUF_DEPTH = 32;
    localparam int BUF_AW    = $clog2(BUF_DEPTH);

    // ICB field widths
    localparam int ICB_AW = 32;
    localparam int ICB_DW = 32;

    // Beat counter width: holds 0..BUF_DEPTH inclusive
    localparam int CNT_W = 6;

    // Responder word indices decoded from addr[4:0]
    localparam int REG_STEP_FIRST = 0;
    localparam int REG_STEP_LAST  = 11;
    localparam int REG_POS_FIRST  = 12;
    localparam int REG_POS_LAST   = 23;
    localparam int REG_EN_FIRST   = 24;
    localparam int REG_EN_LAST    = 28;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CMD  = 2'd1,
        ST_RSP  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    // True when the beat at idx is the final one of a count-beat job
    function automatic logic is_last_beat(input logic [CNT_W-1:0] idx,
                                          input logic [CNT_W-1:0] count);
        return (idx + CNT_W'(1)) == count;
    endfunction

endpackage

// File: rtl/icb_ra_wordbuf.sv
// rtl/icb_ra_wordbuf.sv - 32x32 word buffer: one write port, registered host read, core lookup
module icb_ra_wordbuf
    import icb_ra_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [BUF_AW-1:0] waddr,
    input  logic [ICB_DW-1:0] wdata,
    input  logic [BUF_AW-1:0] raddr,
    output logic [ICB_DW-1:0] rdata,
    input  logic [BUF_AW-1:0] laddr,
    output logic [ICB_DW-1:0] ldata
);

    logic [ICB_DW-1:0] mem [BUF_DEPTH];

    // Single write port; contents deliberately survive reset
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Host read port with one cycle of latency
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata <= '0;
        end else begin
            rdata <= mem[raddr];
        end
    end

    // Core lookup feeds the command wdata register directly
    assign ldata = mem[laddr];

endmodule

// File: rtl/icb_ra_initiator.sv
// rtl/icb_ra_initiator.sv - ICB register-access initiator; ICB_RA_TIMEOUT_EN adds a response timeout
module icb_ra_initiator
    import icb_ra_pkg::*;
#(
    parameter int unsigned ADDR_STRIDE = 1,
    parameter int unsigned TIMEOUT_CYC = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ICB_AW-1:0] cfg_base_addr,
    input  logic [CNT_W-1:0]  cfg_count,
    input  logic              cfg_read,
    input  logic              buf_we,
    input  logic [BUF_AW-1:0] buf_waddr,
    input  logic [ICB_DW-1:0] buf_wdata,
    input  logic [BUF_AW-1:0] buf_raddr,
    output logic [ICB_DW-1:0] buf_rdata,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [CNT_W-1:0]  beats_done,
    output logic              o_icb_cmd_valid,
    input  logic              o_icb_cmd_ready,
    output logic [ICB_AW-1:0] o_icb_cmd_addr,
    output logic              o_icb_cmd_read,
    output logic [ICB_DW-1:0] o_icb_cmd_wdata,
    input  logic              o_icb_rsp_valid,
    output logic              o_icb_rsp_ready,
    input  logic [ICB_DW-1:0] o_icb_rsp_rdata
);

    state_t            state;
    logic [CNT_W-1:0]  idx;
    logic [CNT_W-1:0]  count;
    logic              job_read;

    logic              beat_fire;
    logic              last_beat;
    logic [BUF_AW-1:0] lookup_addr;
    logic [ICB_DW-1:0] lookup_data;
    logic              wr_en;
    logic [BUF_AW-1:0] wr_addr;
    logic [ICB_DW-1:0] wr_data;

`ifdef ICB_RA_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);
    logic [TMO_W-1:0] tmo_cnt;
`else
    // The limit only matters when the timeout is built in
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = |TIMEOUT_CYC;
`endif

    // idx always equals the number of completed beats
    assign beats_done = idx;

    // Beat completion, next-word lookup and buffer write-source selection
    always_comb begin
        beat_fire   = ((state == ST_CMD) && o_icb_cmd_ready && o_icb_rsp_valid) ||
                      ((state == ST_RSP) && o_icb_rsp_valid);
        last_beat   = is_last_beat(idx, count);
        lookup_addr = (state == ST_IDLE) ? '0 : BUF_AW'(idx + CNT_W'(1));
        if (state == ST_IDLE) begin
            wr_en   = buf_we;
            wr_addr = buf_waddr;
            wr_data = buf_wdata;
        end else begin
            wr_en   = beat_fire && job_read;
            wr_addr = idx[BUF_AW-1:0];
            wr_data = o_icb_rsp_rdata;
        end
    end

    icb_ra_wordbuf u_wordbuf (
        .clk   (clk),
        .rst   (rst),
        .we    (wr_en),
        .waddr (wr_addr),
        .wdata (wr_data),
        .raddr (buf_raddr),
        .rdata (buf_rdata),
        .laddr (lookup_addr),
        .ldata (lookup_data)
    );

    // Job sequencer: one outstanding transaction, all interface outputs registered
    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= ST_IDLE;
            idx             <= '0;
            count           <= '0;
            job_read        <= 1'b0;
            busy            <= 1'b0;
            done            <= 1'b0;
            err             <= 1'b0;
            o_icb_cmd_valid <= 1'b0;
            o_icb_rsp_ready <= 1'b0;
            o_icb_cmd_addr  <= '0;
            o_icb_cmd_read  <= 1'b0;
            o_icb_cmd_wdata <= '0;
`ifdef ICB_RA_TIMEOUT_EN
            tmo_cnt         <= '0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        count    <= cfg_count;
                        job_read <= cfg_read;
                        idx      <= '0;
                        err      <= 1'b0;
                        busy     <= 1'b1;
                        if (cfg_count == '0) begin
                            state <= ST_DONE;
                        end else begin
                            state           <= ST_CMD;
                            o_icb_cmd_valid <= 1'b1;
                            o_icb_rsp_ready <= 1'b1;
                            o_icb_cmd_addr  <= cfg_base_addr;
                            o_icb_cmd_read  <= cfg_read;
                            o_icb_cmd_wdata <= cfg_read ? '0 : lookup_data;
                        end
                    end
                end
                ST_CMD: begin
                    // Fields hold while ready is low; only the accept moves us on
                    if (o_icb_cmd_ready) begin
                        o_icb_cmd_valid <= 1'b0;
                        if (!o_icb_rsp_valid) begin
                            state <= ST_RSP;
`ifdef ICB_RA_TIMEOUT_EN
                            tmo_cnt <= '0;
`endif
                        end
                    end
                end
                ST_RSP: begin
`ifdef ICB_RA_TIMEOUT_EN
                    if (!o_icb_rsp_valid) begin
                        if (tmo_cnt == TMO_W'(TIMEOUT_CYC - 1)) begin
                            err             <= 1'b1;
                            state           <= ST_DONE;
                            o_icb_rsp_ready <= 1'b0;
                        end else begin
                            tmo_cnt <= tmo_cnt + TMO_W'(1);
                        end
                    end
`endif
                end
                ST_DONE: begin
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase

            // A completed beat overrides the per-state updates above
            if (beat_fire) begin
                idx <= idx + CNT_W'(1);
                if (last_beat) begin
                    state           <= ST_DONE;
                    o_icb_cmd_valid <= 1'b0;
                    o_icb_rsp_ready <= 1'b0;
                end else begin
                    state           <= ST_CMD;
                    o_icb_cmd_valid <= 1'b1;
                    o_icb_rsp_ready <= 1'b1;
                    o_icb_cmd_addr  <= o_icb_cmd_addr + ICB_AW'(ADDR_STRIDE);
                    o_icb_cmd_wdata <= job_read ? '0 : lookup_data;
                end
            end
        end
    end

endmodule

// File: tb/tb_icb_ra_initiator.sv
// tb/tb_icb_ra_initiator.sv - randomized scoreboard bench for icb_ra_initiator
module tb_icb_ra_initiator;

    localparam int STRIDE = 1;
    localparam int TMO    = 8;
    localparam int NONE   = 1000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [31:0] cfg_base_addr = '0;
    logic [5:0]  cfg_count = '0;
    logic        cfg_read = 1'b0;
    logic        buf_we = 1'b0;
    logic [4:0]  buf_waddr = '0;
    logic [31:0] buf_wdata = '0;
    logic [4:0]  buf_raddr = '0;
    logic [31:0] buf_rdata;
    logic        busy, done, err;
    logic [5:0]  beats_done;
    logic        o_icb_cmd_valid;
    logic        o_icb_cmd_ready = 1'b0;
    logic [31:0] o_icb_cmd_addr;
    logic        o_icb_cmd_read;
    logic [31:0] o_icb_cmd_wdata;
    logic        o_icb_rsp_valid = 1'b0;
    logic        o_icb_rsp_ready;
    logic [31:0] o_icb_rsp_rdata = '0;

    always #5 clk = ~clk;

    icb_ra_initiator #(.ADDR_STRIDE(STRIDE), .TIMEOUT_CYC(TMO)) dut (
        .clk(clk), .rst(rst), .start(start),
        .cfg_base_addr(cfg_base_addr), .cfg_count(cfg_count), .cfg_read(cfg_read),
        .buf_we(buf_we), .buf_waddr(buf_waddr), .buf_wdata(buf_wdata),
        .buf_raddr(buf_raddr), .buf_rdata(buf_rdata),
        .busy(busy), .done(done), .err(err), .beats_done(beats_done),
        .o_icb_cmd_valid(o_icb_cmd_valid), .o_icb_cmd_ready(o_icb_cmd_ready),
        .o_icb_cmd_addr(o_icb_cmd_addr), .o_icb_cmd_read(o_icb_cmd_read),
        .o_icb_cmd_wdata(o_icb_cmd_wdata),
        .o_icb_rsp_valid(o_icb_rsp_valid), .o_icb_rsp_ready(o_icb_rsp_ready),
        .o_icb_rsp_rdata(o_icb_rsp_rdata)
    );

    typedef struct packed {
        logic [31:0] addr;
        logic        rd;
        logic [31:0] wdata;
    } cmd_t;

    typedef struct packed {
        logic [5:0] beats;
        logic       err;
    } done_t;

    cmd_t        cmd_q[$];
    done_t       done_q[$];
    logic [31:0] model_buf [32];
    int          n_vec = 0;
    int          n_fail = 0;

    // Responder behaviour, written only by the main process
    logic [31:0] job_base = '0;
    int          rsp_lat = 0;
    int          stall_beat = NONE;
    int          stall_len = 0;
    int          silent_beat = NONE;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
        end
    endtask

    // Responder: stalls ready on one beat, answers after rsp_lat cycles, can stay silent
    initial begin : responder
        int          beat;
        logic [31:0] a;
        @(negedge clk);
        forever begin
            o_icb_cmd_ready = 1'b0;
            o_icb_rsp_valid = 1'b0;
            if (o_icb_cmd_valid && !rst) begin
                a    = o_icb_cmd_addr;
                beat = int'((a - job_base) / STRIDE);
                if (beat == stall_beat) repeat (stall_len) @(negedge clk);
                o_icb_cmd_ready = 1'b1;
                if (rsp_lat == 0 && beat != silent_beat) begin
                    o_icb_rsp_valid = 1'b1;
                    o_icb_rsp_rdata = 32'hA000 + a;
                end
                @(negedge clk);
                o_icb_cmd_ready = 1'b0;
                o_icb_rsp_valid = 1'b0;
                if (rsp_lat > 0 && beat != silent_beat) begin
                    repeat (rsp_lat - 1) @(negedge clk);
                    o_icb_rsp_valid = 1'b1;
                    o_icb_rsp_rdata = 32'hA000 + a;
                    @(negedge clk);
                end
            end else begin
                @(negedge clk);
            end
        end
    end

    // Monitor: compares every command handshake and done pulse against the queues
    initial begin : monitor
        logic  held;
        cmd_t  hold_cmd;
        cmd_t  exp_c;
        done_t exp_d;
        held = 1'b0;
        forever begin
            @(negedge clk);
            #1;
            if (rst) begin
                held = 1'b0;
                continue;
            end
            if (held && o_icb_cmd_valid) begin
                check("hold_addr", o_icb_cmd_addr, hold_cmd.addr);
                check("hold_wdata", o_icb_cmd_wdata, hold_cmd.wdata);
                check("hold_read", 32'(o_icb_cmd_read), 32'(hold_cmd.rd));
            end
            held     = o_icb_cmd_valid && !o_icb_cmd_ready;
            hold_cmd = '{addr: o_icb_cmd_addr, rd: o_icb_cmd_read, wdata: o_icb_cmd_wdata};
            if (o_icb_cmd_valid) begin
                check("rsp_ready_in_cmd", 32'(o_icb_rsp_ready), 32'd1);
            end
            if (o_icb_cmd_valid && o_icb_cmd_ready) begin
                check("cmd_expected", 32'(cmd_q.size() != 0), 32'd1);
                if (cmd_q.size() != 0) begin
                    exp_c = cmd_q.pop_front();
                    check("cmd_addr", o_icb_cmd_addr, exp_c.addr);
                    check("cmd_read", 32'(o_icb_cmd_read), 32'(exp_c.rd));
                    check("cmd_wdata", o_icb_cmd_wdata, exp_c.wdata);
                end
            end
            if (done) begin
                check("done_expected", 32'(done_q.size() != 0), 32'd1);
                if (done_q.size() != 0) begin
                    exp_d = done_q.pop_front();
                    check("done_beats", 32'(beats_done), 32'(exp_d.beats));
                    check("done_err", 32'(err), 32'(exp_d.err));
                    check("done_busy", 32'(busy), 32'd0);
                    check("done_rsp_ready", 32'(o_icb_rsp_ready), 32'd0);
                end
            end
        end
    end

    task automatic check_reset_outputs(input string tag);
        check({tag, "_busy"}, 32'(busy), 0);
        check({tag, "_done"}, 32'(done), 0);
        check({tag, "_err"}, 32'(err), 0);
        check({tag, "_beats"}, 32'(beats_done), 0);
        check({tag, "_cmd_valid"}, 32'(o_icb_cmd_valid), 0);
        check({tag, "_rsp_ready"}, 32'(o_icb_rsp_ready), 0);
        check({tag, "_addr"}, o_icb_cmd_addr, 0);
        check({tag, "_wdata"}, o_icb_cmd_wdata, 0);
        check({tag, "_read"}, 32'(o_icb_cmd_read), 0);
        check({tag, "_buf_rdata"}, buf_rdata, 0);
    endtask

    task automatic host_write(input logic [4:0] a, input logic [31:0] d);
        buf_we    = 1'b1;
        buf_waddr = a;
        buf_wdata = d;
        @(negedge clk);
        #1;
        buf_we = 1'b0;
        model_buf[a] = d;
    endtask

    task automatic readback();
        for (int i = 0; i < 32; i++) begin
            buf_raddr = 5'(i);
            @(negedge clk);
            #1;
            check($sformatf("buf[%0d]", i), buf_rdata, model_buf[i]);
        end
    endtask

    // Builds the expected transcript of a job from its configuration, then runs it
    task automatic run_job(input logic [31:0] base, input int count, input logic rd,
                           input int lat, input int sb, input int sl, input int silent,
                           input bit poke, input bit restart);
        int          n_issue, n_done, cycles, exp_cycles;
        logic [31:0] a;
        bit          aborted;
        aborted = (silent < count);
        n_issue = aborted ? silent + 1 : count;
        n_done  = aborted ? silent : count;
        for (int i = 0; i < n_issue; i++) begin
            a = base + 32'(i * STRIDE);
            cmd_q.push_back('{addr: a, rd: rd, wdata: rd ? 32'h0 : model_buf[i]});
        end
        if (rd) begin
            for (int i = 0; i < n_done; i++) model_buf[i] = 32'hA000 + base + 32'(i * STRIDE);
        end
        done_q.push_back('{beats: 6'(n_done), err: aborted});
        job_base    = base;
        rsp_lat     = lat;
        stall_beat  = sb;
        stall_len   = sl;
        silent_beat = silent;
        cfg_base_addr = base;
        cfg_count     = 6'(count);
        cfg_read      = rd;
        start         = 1'b1;
        @(negedge clk);
        #1;
        start  = 1'b0;
        cycles = 1;
        check("busy_after_start", 32'(busy), 1);
        check("err_cleared", 32'(err), 0);
        check("beats_cleared", 32'(beats_done), 0);
        while (!done && cycles < 4000) begin
            if (poke) begin
                buf_we    = (cycles == 1);
                buf_waddr = 5'd0;
                buf_wdata = 32'hDEAD_BEEF;
            end
            if (restart) begin
                start         = (cycles == 2);
                cfg_count     = 6'd7;
                cfg_read      = ~rd;
                cfg_base_addr = 32'h5555;
            end
            @(negedge clk);
            #1;
            cycles++;
        end
        buf_we = 1'b0;
        start  = 1'b0;
        check("done_seen", 32'(done), 1);
        exp_cycles = count * (1 + lat) + 2 + ((sb < count) ? sl : 0);
        if (!aborted) check("job_cycles", 32'(cycles), 32'(exp_cycles));
        stall_beat  = NONE;
        silent_beat = NONE;
    endtask

    initial begin : main
        logic [31:0] base;
        logic        rd;
        int          cnt;

        repeat (2) @(negedge clk);
        #1;
        check_reset_outputs("reset");
        rst = 1'b0;

        for (int i = 0; i < 32; i++) host_write(5'(i), 32'(100 + i));

        // Back-to-back write beats, with a host write attempted mid-job
        run_job(32'd0, 12, 1'b0, 0, NONE, 0, NONE, 1'b1, 1'b0);
        readback();

        // Read job answered one cycle after each accept
        run_job(32'd12, 12, 1'b1, 1, NONE, 0, NONE, 1'b0, 1'b0);
        readback();

        // Ready held low for 5 cycles on beat 3
        run_job(32'd3, 8, 1'b0, 0, 3, 5, NONE, 1'b0, 1'b0);

        // Zero-length job, then a start pulse while busy
        run_job(32'd9, 0, 1'b0, 0, NONE, 0, NONE, 1'b0, 1'b0);
        run_job(32'd200, 6, 1'b0, 1, NONE, 0, NONE, 1'b0, 1'b1);

        // Reset while waiting for a response aborts without a done pulse
        job_base    = 32'd12;
        rsp_lat     = 1;
        silent_beat = 1;
        cmd_q.push_back('{addr: 32'd12, rd: 1'b1, wdata: 32'h0});
        cmd_q.push_back('{addr: 32'd13, rd: 1'b1, wdata: 32'h0});
        model_buf[0]  = 32'hA000 + 32'd12;
        cfg_base_addr = 32'd12;
        cfg_count     = 6'd4;
        cfg_read      = 1'b1;
        start         = 1'b1;
        @(negedge clk);
        #1;
        start = 1'b0;
        repeat (8) @(negedge clk);
        #1;
        check("rsp_wait_cmds", 32'(cmd_q.size()), 0);
        rst = 1'b1;
        @(negedge clk);
        #1;
        rst = 1'b0;
        check_reset_outputs("rst_mid");
        silent_beat = NONE;
        repeat (3) @(negedge clk);
        #1;
        run_job(32'd100, 4, 1'b1, 0, NONE, 0, NONE, 1'b0, 1'b0);
        readback();

`ifdef ICB_RA_TIMEOUT_EN
        // Silent responder on beat 2, then the next job clears err
        run_job(32'd40, 5, 1'b0, 0, NONE, 0, 2, 1'b0, 1'b0);
        run_job(32'd0, 1, 1'b0, 0, NONE, 0, NONE, 1'b0, 1'b0);
`endif

        // Randomized jobs, including address wrap near 2^32
        for (int j = 0; j < 24; j++) begin
            repeat ($urandom_range(0, 3)) host_write(5'($urandom_range(0, 31)), $urandom);
            base = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF0 + 32'($urandom_range(0, 15)) : $urandom;
            rd   = 1'($urandom_range(0, 1));
            cnt  = int'($urandom_range(0, 32));
            run_job(base, cnt, rd, int'($urandom_range(0, 2)), int'($urandom_range(0, 40)),
                    int'($urandom_range(0, 4)), NONE, 1'b0, 1'b0);
            readback();
        end

        repeat (3) @(negedge clk);
        #1;
        check("cmd_q_drained", 32'(cmd_q.size()), 0);
        check("done_q_drained", 32'(done_q.size()), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
